// File: rtl/traffic_pkg.sv
// Shared light codes and phase encoding for the intersection controllers.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10
  } light_e;

  typedef enum logic [2:0] {
    PH_ALL_RED   = 3'd0,
    PH_NS_GREEN  = 3'd1,
    PH_NS_YELLOW = 3'd2,
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_PED_WALK  = 3'd5
  } phase_e;

  typedef enum logic {
    ROAD_NS = 1'b0,
    ROAD_EW = 1'b1
  } road_e;

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor inputs and lamp outputs of the phase scheduler.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic       ped_waiting;
  logic [2:0] phase;

  modport master (
    output tick, ns_car, ew_car, ped_req,
    input  ns_light, ew_light, walk, ped_waiting, phase
  );

  modport slave (
    input  tick, ns_car, ew_car, ped_req,
    output ns_light, ew_light, walk, ped_waiting, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Per-phase tick counter: cleared on state entry, counts ticks, saturates.
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr_i,
  input  logic               tick_i,
  output logic [TIMER_W-1:0] timer_o,
  output logic [TIMER_W-1:0] count_o
);

  localparam logic [TIMER_W-1:0] TMAX = '1;

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;

  // Tick count including a tick on the current edge (saturating).
  always_comb begin
    count_o = timer_q;
    if (tick_i && (timer_q != TMAX)) count_o = timer_q + TIMER_W'(1);
  end

  // A state change restarts the count from zero.
  always_comb begin
    timer_d = clr_i ? '0 : count_o;
  end

  // Timer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer_q <= '0;
    else          timer_q <= timer_d;
  end

  assign timer_o = timer_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven green/yellow/all-red/walk sequencer for a two-road crossing.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TIMER_W      = 8,
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 40,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  traffic_phase_scheduler_if.slave   bus
);

  localparam logic [TIMER_W-1:0] MIN_T    = TIMER_W'(MIN_GREEN);
  localparam logic [TIMER_W-1:0] MAX_T    = TIMER_W'(MAX_GREEN);
  localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_LAST  = TIMER_W'(ALL_RED_TIME - 1);
  localparam logic [TIMER_W-1:0] WLK_LAST = TIMER_W'(WALK_TIME - 1);

  phase_e             state_q, state_d;
  road_e              last_green_q, last_green_d;
  logic               ped_pending_q, ped_pending_d;
  logic               ped_served_q, ped_served_d;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] count;
  logic               clr;

  // A fixed-length phase of D ticks ends on the tick that sees timer == D-1.
  function automatic logic fixed_done(input logic tck, input logic [TIMER_W-1:0] t,
                                      input logic [TIMER_W-1:0] last);
    return tck && (t == last);
  endfunction

  // Green thresholds compare against the count including this edge's tick,
  // so a green with waiting opposition lasts exactly MIN_GREEN ticks.
  function automatic logic green_exit(input logic [TIMER_W-1:0] cnt,
                                      input logic own_car, input logic opp);
    return opp && (((cnt >= MIN_T) && !own_car) || (cnt >= MAX_T));
  endfunction

  assign clr = (state_d != state_q);

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr),
    .tick_i  (bus.tick),
    .timer_o (timer),
    .count_o (count)
  );

  // State, last-served road and pedestrian latch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= PH_ALL_RED;
      last_green_q  <= ROAD_EW;
      ped_pending_q <= 1'b0;
      ped_served_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_green_q  <= last_green_d;
      ped_pending_q <= ped_pending_d;
      ped_served_q  <= ped_served_d;
    end
  end

  // Next-state decisions; a button press always wins over the walk-exit clear.
  always_comb begin
    state_d       = state_q;
    last_green_d  = last_green_q;
    ped_pending_d = ped_pending_q | bus.ped_req;
    ped_served_d  = ped_served_q;
    case (state_q)
      PH_ALL_RED: begin
        if (fixed_done(bus.tick, timer, AR_LAST)) begin
          if (ped_pending_q && !ped_served_q) state_d = PH_PED_WALK;
          else if (last_green_q == ROAD_NS)   state_d = PH_EW_GREEN;
          else                                state_d = PH_NS_GREEN;
        end
      end
      PH_NS_GREEN: begin
        if (green_exit(count, bus.ns_car, bus.ew_car | ped_pending_q)) state_d = PH_NS_YELLOW;
      end
      PH_NS_YELLOW: begin
        if (fixed_done(bus.tick, timer, YEL_LAST)) begin
          state_d      = PH_ALL_RED;
          last_green_d = ROAD_NS;
        end
      end
      PH_EW_GREEN: begin
        if (green_exit(count, bus.ew_car, bus.ns_car | ped_pending_q)) state_d = PH_EW_YELLOW;
      end
      PH_EW_YELLOW: begin
        if (fixed_done(bus.tick, timer, YEL_LAST)) begin
          state_d      = PH_ALL_RED;
          last_green_d = ROAD_EW;
        end
      end
      PH_PED_WALK: begin
        if (fixed_done(bus.tick, timer, WLK_LAST)) begin
          state_d       = PH_ALL_RED;
          ped_pending_d = bus.ped_req;
          ped_served_d  = 1'b1;
        end
      end
      default: state_d = PH_ALL_RED;
    endcase
    if (clr && ((state_d == PH_NS_GREEN) || (state_d == PH_EW_GREEN))) ped_served_d = 1'b0;
  end

  // Moore lamp decode from the registered state.
  always_comb begin
    bus.ns_light    = LIGHT_RED;
    bus.ew_light    = LIGHT_RED;
    bus.walk        = 1'b0;
    bus.ped_waiting = ped_pending_q;
    bus.phase       = state_q;
    case (state_q)
      PH_NS_GREEN:  bus.ns_light = LIGHT_GREEN;
      PH_NS_YELLOW: bus.ns_light = LIGHT_YELLOW;
      PH_EW_GREEN:  bus.ew_light = LIGHT_GREEN;
      PH_EW_YELLOW: bus.ew_light = LIGHT_YELLOW;
      PH_PED_WALK:  bus.walk     = 1'b1;
      default:      bus.walk     = 1'b0;
    endcase
  end

endmodule
